// File: rtl/spi_sat_multi.sv
// spi_sat_multi: full-duplex SPI master with per-transfer byte length,
// runtime chip-select selection, all four CPOL/CPHA modes and busy status.
// Sequence per transfer: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
// Optional feature macro: SPI_SAT_MULTI_LSB_FIRST_EN enables LSB-first
// transfers through the lsb_first port. Without it the port is ignored.
module spi_sat_multi #(
   parameter  int MAX_LEN  = 4,
   parameter  int CS_NUM   = 4,
   parameter  int SCLK_DIV = 2,
   localparam int W        = MAX_LEN * 8,
   localparam int LEN_W    = $clog2(MAX_LEN + 1),
   localparam int CS_W     = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W-1:0]      cmd,
   input  logic [LEN_W-1:0]  len,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic              trmt,
   input  logic              clr_rdy,
   output logic              busy,
   output logic              rx_rdy,
   output logic [W-1:0]      resp,
   output logic              SPI_SCLK,
   output logic              SPI_MOSI,
   input  logic              SPI_MISO,
   output logic [CS_NUM-1:0] SPI_CS
);

   localparam int NB_W   = $clog2(W + 1);
   localparam int EDGE_W = NB_W + 1;
   localparam int CNT_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [EDGE_W-1:0]   edge_q;
   logic [NB_W-1:0]     nbits_q;
   logic [W-1:0]        tx_q;
   logic [W-1:0]        rx_q;
   logic                cpol_q;
   logic                cpha_q;
   logic                lsb_q;
   logic                sclk_q;
   logic                mosi_q;
   logic [CS_NUM-1:0]   cs_q;
   logic                busy_q;
   logic                rdy_q;
   logic [W-1:0]        resp_q;

   logic                lsb_en;
   logic [NB_W-1:0]     nbits_d;
   logic [W-1:0]        tx_d;
   logic [CS_NUM-1:0]   cs_d;
   logic [W-1:0]        rx_d;
   logic [W-1:0]        resp_d;
   logic [EDGE_W-1:0]   edge_d;
   logic                cnt_end;
   logic                last_half;
   logic                do_sample;
   logic                do_shift;

`ifdef SPI_SAT_MULTI_LSB_FIRST_EN
   assign lsb_en = lsb_first;
`else
   logic unused_lsb_first;
   assign unused_lsb_first = lsb_first;
   assign lsb_en = 1'b0;
`endif

   // Start-of-transfer values, per-edge decisions and received-word alignment.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      nbits_d = (len == '0) ? NB_W'(W) : NB_W'({len, 3'b000});
      // The first bit to send always sits at tx MSB; later bits shift up behind it.
      tx_d = cmd << (NB_W'(W) - nbits_d);
      if (lsb_en) begin
         for (int i = 0; i < W; i++) tx_d[W-1-i] = cmd[i];
      end
      cs_d = '1;
      if (int'(cs_sel) < CS_NUM) cs_d[cs_sel] = 1'b0;

      edge_d    = edge_q + EDGE_W'(1);
      cnt_end   = (cnt_q == CNT_W'(SCLK_DIV - 1));
      last_half = (edge_q == {nbits_q, 1'b0});
      // Odd edges are leading edges. CPHA=0 samples there; CPHA=1 samples on trailing ones.
      do_sample = cpha_q ? ~edge_d[0] : edge_d[0];
      do_shift  = cpha_q ? (edge_d[0] && edge_d != EDGE_W'(1))
                         : (!edge_d[0] && edge_d != {nbits_q, 1'b0});

      rx_d   = lsb_q ? {SPI_MISO, rx_q[W-1:1]} : {rx_q[W-2:0], SPI_MISO};
      // LSB-first bits collect at the top and are moved down so resp is right-aligned.
      resp_d = lsb_q ? (rx_q >> (NB_W'(W) - nbits_q)) : rx_q;
   end

   // Transfer FSM with all SPI pins and status held in registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         edge_q  <= '0;
         nbits_q <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_q    <= '1;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees the pre-edge values.
         case (state_q)
            IDLE: begin
               sclk_q <= cpol;
               if (trmt) begin
                  state_q <= SETUP;
                  cnt_q   <= '0;
                  edge_q  <= '0;
                  nbits_q <= nbits_d;
                  tx_q    <= tx_d;
                  mosi_q  <= tx_d[W-1];
                  rx_q    <= '0;
                  cpol_q  <= cpol;
                  cpha_q  <= cpha;
                  lsb_q   <= lsb_en;
                  cs_q    <= cs_d;
                  busy_q  <= 1'b1;
                  rdy_q   <= 1'b0;
                  resp_q  <= '0;
               end else if (clr_rdy) begin
                  rdy_q <= 1'b0;
               end
            end
            SETUP, XFER: begin
               if (!cnt_end) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  cnt_q <= '0;
                  if (last_half) begin
                     state_q <= HOLD;
                  end else begin
                     state_q <= XFER;
                     sclk_q  <= ~sclk_q;
                     edge_q  <= edge_d;
                     if (do_sample) rx_q <= rx_d;
                     if (do_shift) begin
                        tx_q   <= tx_q << 1;
                        mosi_q <= tx_q[W-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (!cnt_end) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end else begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  sclk_q  <= cpol_q;
                  cs_q    <= '1;
                  busy_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  resp_q  <= resp_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign rx_rdy   = rdy_q;
   assign resp     = resp_q;
   assign SPI_SCLK = sclk_q;
   assign SPI_MOSI = mosi_q;
   assign SPI_CS   = cs_q;

endmodule

// File: tb/tb_spi_sat_multi.sv
// tb_spi_sat_multi: directed bench for spi_sat_multi (MAX_LEN=4, CS_NUM=4,
// SCLK_DIV=2) with loopback and a small byte-wide SPI slave model.
module tb_spi_sat_multi;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cmd;
   logic [2:0]  len;
   logic [1:0]  cs_sel;
   logic        cpol, cpha, lsb_first, trmt, clr_rdy;
   logic        busy, rx_rdy;
   logic [31:0] resp;
   logic        SPI_SCLK, SPI_MOSI, SPI_MISO;
   logic [3:0]  SPI_CS;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc, cs_low, pulse_total, pulse_base;
   logic [3:0] cs_mask;
   bit   loopback, inject_mid;

   // slave model state
   logic [7:0] s_data;
   logic       s_lsb;
   logic       s_miso = 1'b0;
   int         s_bit = 0;
   logic       s_prev_act = 1'b0;
   logic       s_prev_sclk = 1'b0;

   spi_sat_multi #(.MAX_LEN(4), .CS_NUM(4), .SCLK_DIV(2)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd), .len(len), .cs_sel(cs_sel),
      .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .trmt(trmt),
      .clr_rdy(clr_rdy), .busy(busy), .rx_rdy(rx_rdy), .resp(resp),
      .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
      .SPI_CS(SPI_CS)
   );

   always #5 clk = ~clk;

   assign SPI_MISO = loopback ? SPI_MOSI : s_miso;

   function automatic logic sbit(input int i);
      if (i > 7) return 1'b0;
      return s_lsb ? s_data[i[2:0]] : s_data[3'(7 - i)];
   endfunction

   // Slave: drives on the leading edge for CPHA=1, on CS fall / trailing edges for CPHA=0.
   always @(SPI_CS or SPI_SCLK) begin
      if (SPI_CS != 4'hF && !s_prev_act) begin
         s_bit = 0;
         if (!cpha) s_miso = sbit(0);
      end else if (SPI_CS != 4'hF && SPI_SCLK != s_prev_sclk) begin
         if (cpha && SPI_SCLK != cpol) begin
            s_miso = sbit(s_bit);
            s_bit++;
         end else if (!cpha && SPI_SCLK == cpol) begin
            s_bit++;
            s_miso = sbit(s_bit);
         end
      end
      s_prev_act  = (SPI_CS != 4'hF);
      s_prev_sclk = SPI_SCLK;
   end

   // Count SCLK leading edges while some chip select is low.
   always @(SPI_SCLK) begin
      if (SPI_CS != 4'hF && SPI_SCLK != cpol) pulse_total++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge after the trmt edge (cyc=1).
   task automatic start_xfer(input logic [31:0] c, input logic [2:0] l, input logic [1:0] s,
                             input logic p, input logic h, input logic lsb,
                             input logic clr, input logic b2b);
      cpol = p;
      cpha = h;
      if (!b2b) @(negedge clk);
      cmd = c; len = l; cs_sel = s; lsb_first = lsb;
      trmt = 1'b1; clr_rdy = clr;
      pulse_base = pulse_total;
      @(negedge clk);
      trmt = 1'b0; clr_rdy = 1'b0;
      cyc     = 1;
      cs_mask = ~SPI_CS;
      cs_low  = (SPI_CS != 4'hF) ? 1 : 0;
      check("busy_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      while (!rx_rdy && cyc < 400) begin
         @(negedge clk);
         cyc++;
         cs_mask |= ~SPI_CS;
         if (SPI_CS != 4'hF) cs_low++;
         if (inject_mid && cyc == 20) begin
            cmd  = 32'h1234;
            trmt = 1'b1;
         end else begin
            trmt = 1'b0;
         end
      end
      check(tag, 32'(cyc), 32'(exp_cyc));
   endtask

   initial begin
      rst_n = 1'b0; trmt = 1'b0; clr_rdy = 1'b0; cmd = '0; len = '0; cs_sel = '0;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
      loopback = 1'b1; inject_mid = 1'b0; s_data = '0; s_lsb = 1'b0;
      pulse_total = 0;
      repeat (3) @(negedge clk);
      check("rst_sclk", 32'(SPI_SCLK), 32'd0);
      check("rst_mosi", 32'(SPI_MOSI), 32'd0);
      check("rst_cs",   32'(SPI_CS),   32'hF);
      check("rst_busy", 32'(busy),     32'd0);
      check("rst_rdy",  32'(rx_rdy),   32'd0);
      check("rst_resp", resp,          32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Loopback, mode 0, len=2 -> 16 bits, rx_rdy at cycle 1+2*34
      start_xfer(32'hA55A, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("a_cs_sel", 32'(SPI_CS), 32'hE);
      wait_done("a_cycles", 69);
      check("a_resp",   resp, 32'h0000A55A);
      check("a_cs_low", 32'(cs_low), 32'd68);
      check("a_pulses", 32'(pulse_total - pulse_base), 32'd16);
      check("a_busy_end", 32'(busy), 32'd0);
      check("a_cs_end", 32'(SPI_CS), 32'hF);

      // clr_rdy clears; a second clr_rdy with rx_rdy=0 changes nothing
      clr_rdy = 1'b1; @(negedge clk); clr_rdy = 1'b0;
      check("clr_rdy", 32'(rx_rdy), 32'd0);
      check("clr_keeps_resp", resp, 32'h0000A55A);
      clr_rdy = 1'b1; @(negedge clk); clr_rdy = 1'b0;
      check("clr_idle_rdy",  32'(rx_rdy), 32'd0);
      check("clr_idle_busy", 32'(busy),   32'd0);

      // Slave returns 0x3C, mode 3, len=1, cs_sel=2
      loopback = 1'b0; s_data = 8'h3C; s_lsb = 1'b0;
      cpol = 1'b1; cpha = 1'b1;
      @(negedge clk);
      check("b_sclk_idle", 32'(SPI_SCLK), 32'd1);
      start_xfer(32'h00A5, 3'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_done("b_cycles", 37);
      check("b_resp",    resp, 32'h3C);
      check("b_cs_mask", 32'(cs_mask), 32'h4);
      check("b_pulses",  32'(pulse_total - pulse_base), 32'd8);
      check("b_sclk_end", 32'(SPI_SCLK), 32'd1);

      // Loopback, len=0 means four bytes
      loopback = 1'b1;
      start_xfer(32'hDEADBEEF, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_done("c_cycles", 133);
      check("c_resp",   resp, 32'hDEADBEEF);
      check("c_pulses", 32'(pulse_total - pulse_base), 32'd32);

      // trmt while busy is ignored; the new trmt also clears the old rx_rdy
      inject_mid = 1'b1;
      start_xfer(32'hA55A, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("d_rdy_cleared", 32'(rx_rdy), 32'd0);
      wait_done("d_cycles", 69);
      inject_mid = 1'b0;
      check("d_resp",   resp, 32'h0000A55A);
      check("d_pulses", 32'(pulse_total - pulse_base), 32'd16);

      // Reset during bit 5 aborts at once
      start_xfer(32'hA55A, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      while ((pulse_total - pulse_base) < 5 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("e_reached_bit5", 32'(pulse_total - pulse_base), 32'd5);
      rst_n = 1'b0;
      #1;
      check("e_sclk", 32'(SPI_SCLK), 32'd0);
      check("e_mosi", 32'(SPI_MOSI), 32'd0);
      check("e_cs",   32'(SPI_CS),   32'hF);
      check("e_busy", 32'(busy),     32'd0);
      check("e_rdy",  32'(rx_rdy),   32'd0);
      check("e_resp", resp,          32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      begin
         int rdy_seen = 0;
         repeat (80) begin
            @(negedge clk);
            if (rx_rdy) rdy_seen++;
         end
         check("e_no_rdy", 32'(rdy_seen), 32'd0);
      end
      start_xfer(32'h5AA5, 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_done("e2_cycles", 69);
      check("e2_resp", resp, 32'h00005AA5);

      // lsb_first: cmd=0x01, slave sends 0x80 LSB-first (mode 0)
      loopback = 1'b0; s_data = 8'h80; s_lsb = 1'b1;
      start_xfer(32'h01, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SPI_SAT_MULTI_LSB_FIRST_EN
      check("f_mosi_first", 32'(SPI_MOSI), 32'd1);
      wait_done("f_cycles", 37);
      check("f_resp", resp, 32'h80);
`else
      check("f_mosi_first", 32'(SPI_MOSI), 32'd0);
      wait_done("f_cycles", 37);
      check("f_resp", resp, 32'h01);
`endif

      // trmt with clr_rdy in the same cycle: the start wins; mode 1 loopback
      loopback = 1'b1;
      start_xfer(32'hC3, 3'd1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("g_rdy_low", 32'(rx_rdy), 32'd0);
      check("g_cs_sel",  32'(SPI_CS), 32'h7);
      wait_done("g_cycles", 37);
      check("g_resp",   resp, 32'hC3);
      check("g_cs_gap", 32'(SPI_CS), 32'hF);

      // Back-to-back: start in the first cycle busy is low
      start_xfer(32'h96, 3'd1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("h_cs_low", 32'(SPI_CS), 32'hE);
      wait_done("h_cycles", 37);
      check("h_resp", resp, 32'h96);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
